// File: rtl/seg7_scan_display.sv
// seg7_scan_display
// Time-multiplexed 8-digit common-anode seven-segment driver. It shows a
// 32-bit word as 8 hex digits, scanning one digit every SCAN_DIV cycles.
// A newly loaded word replaces the displayed word only at a frame boundary,
// so a frame never mixes digits of two different words.

module seg7_scan_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_disp_data,
  input  logic        i_load,
  input  logic        i_blank_lz,
  input  logic [7:0]  i_dp_mask,
  output logic [7:0]  o_disp_an,
  output logic [7:0]  o_disp_seg,
  output logic        o_frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic [2:0]    r_dig;
  logic [31:0]   r_pend;
  logic          r_pend_v;
  logic [31:0]   r_shown;

  logic          w_div_last;
  logic          w_boundary;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg7;
  logic          w_blank;
  logic [7:0]    w_an;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_boundary = w_div_last && (r_dig == 3'd7);

  // Digit i sits in nibble i of the displayed word; digit 0 is rightmost.
  assign w_nibble = r_shown[{r_dig, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is exempt so that the word 0 still shows a single "0".
  assign w_blank = i_blank_lz && (r_dig != 3'd0) &&
                   ((r_shown >> {r_dig, 2'b00}) == 32'd0);

  assign w_an = w_blank ? 8'hFF : ~(8'b1 << r_dig);

  // Divider: hold each digit for SCAN_DIV cycles, then step to the next one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_div_cnt <= '0;
      r_dig     <= 3'd0;
    end else if (w_div_last) begin
      r_div_cnt <= '0;
      r_dig     <= r_dig + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Word capture: loads park in the pending register and are promoted only
  // at the frame boundary; a load landing exactly on the boundary bypasses
  // the pending register and discards whatever was waiting there.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pend   <= 32'd0;
      r_pend_v <= 1'b0;
      r_shown  <= 32'd0;
    end else if (w_boundary) begin
      if (i_load) begin
        r_shown  <= i_disp_data;
        r_pend_v <= 1'b0;
      end else if (r_pend_v) begin
        r_shown  <= r_pend;
        r_pend_v <= 1'b0;
      end
    end else if (i_load) begin
      r_pend   <= i_disp_data;
      r_pend_v <= 1'b1;
    end
  end

  // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg7 = 7'h7F;
    case (w_nibble)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;
      4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;
      4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;
      4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
  end

  // Output registers: everything the board sees comes straight from a flop,
  // one cycle behind the digit index; a blanked digit is driven fully dark.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_disp_an    <= 8'hFF;
      o_disp_seg   <= 8'hFF;
      o_frame_tick <= 1'b0;
    end else begin
      o_disp_an    <= w_an;
      o_disp_seg   <= w_blank ? 8'hFF : {~i_dp_mask[r_dig], w_seg7};
      o_frame_tick <= w_boundary;
    end
  end

endmodule
